// File: rtl/flat_stream_unpacker.sv
// Snapshots a packed flatten-stage frame on a rising edge of done, then streams
// its elements one per accepted cycle over a valid/ready handshake.
module flat_stream_unpacker #(
    parameter int bits = 18,
    parameter int size = 784,
    parameter int IW   = $clog2(size)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [bits*size-1:0]   flat_in,
    input  logic                   done,
    output logic signed [bits-1:0] elem_out,
    output logic [IW-1:0]          elem_idx,
    output logic                   elem_valid,
    input  logic                   elem_ready,
    output logic                   elem_last,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_FIN    = 2'd2;

    localparam logic [IW-1:0] LAST_IDX = IW'(size - 1);

    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [bits*size-1:0] shadow_q;
    logic                 done_q;
    logic                 overrun_q, overrun_d;
    logic                 rise;
    logic                 load;
    logic                 accept;

    // done_q starts at 0, so done already high when reset releases counts as a rise.
    assign rise   = done & ~done_q;
    assign load   = (state_q == S_IDLE) & rise;
    assign accept = (state_q == S_STREAM) & elem_ready;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    idx_d     = '0;
                    overrun_d = 1'b0;
                    state_d   = S_STREAM;
                end
            end
            S_STREAM: begin
                if (rise) overrun_d = 1'b1;
                if (accept) begin
                    if (idx_q == LAST_IDX) state_d = S_FIN;
                    else                   idx_d   = idx_q + 1'b1;
                end
            end
            S_FIN: begin
                if (rise) overrun_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            done_q    <= done;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: the wide snapshot is deliberately reset so elem_out reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    shadow_q <= '0;
        else if (load) shadow_q <= flat_in;
    end

    assign elem_out   = shadow_q[int'(idx_q)*bits +: bits];
    assign elem_idx   = idx_q;
    assign elem_valid = (state_q == S_STREAM);
    assign elem_last  = elem_valid & (idx_q == LAST_IDX);
    assign busy       = (state_q != S_IDLE);
    assign frame_done = (state_q == S_FIN);
    assign overrun    = overrun_q;

endmodule
